avalon_fp_mult_master: RTL and testbench

Avalon-MM master that runs batches of operand pairs through the avalon_fp_mult slave without CPU involvement, sitting directly upstream of it. Software writes the source base, destination base and count through a small CSR slave, then starts the batch. For each item the block reads two IEEE-754 single operands from memory, drives the multiplier's op1/op2/start/result register sequence, and writes the product back to memory. Status reports busy, done and the number of completed items.

---
 rtl/fp_mult_pkg.sv | 36 +++
 rtl/avalon_fp_mult_master.sv | 223 ++++++++++++++++++++++
 tb/tb_avalon_fp_mult_master.sv | 374 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_mult_pkg.sv
// Shared types and constants for the batch FP-multiply Avalon master.
package fp_mult_pkg;

  // Batch sequencer states.
  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    LOAD   = 4'd1,
    RD_A   = 4'd2,
    RD_B   = 4'd3,
    WR_OP1 = 4'd4,
    WR_OP2 = 4'd5,
    WR_GO  = 4'd6,
    RD_RES = 4'd7,
    WR_MEM = 4'd8,
    NEXT   = 4'd9,
    DONE   = 4'd10
  } state_e;

  // Register map of the downstream multiplier slave.
  localparam logic [2:0] MUL_OP1    = 3'd0;
  localparam logic [2:0] MUL_OP2    = 3'd1;
  localparam logic [2:0] MUL_START  = 3'd2;
  localparam logic [2:0] MUL_RESULT = 3'd3;

  // CSR map of this block.
  localparam logic [1:0] CSR_SRC  = 2'd0;
  localparam logic [1:0] CSR_DST  = 2'd1;
  localparam logic [1:0] CSR_CNT  = 2'd2;
  localparam logic [1:0] CSR_CTRL = 2'd3;

  // Control/status word layout: completed count in [15:0].
  localparam int CTRL_START_BIT = 0;
  localparam int STAT_BUSY_BIT  = 16;
  localparam int STAT_DONE_BIT  = 17;

endpackage

// File: rtl/avalon_fp_mult_master.sv
// Batch engine: reads operand pairs from memory, pushes them through the
// FP multiplier slave and writes each product back to memory.
//
// Handshake (both master ports): a request is presented by a strobe with its
// address/writedata; everything is held stable while waitrequest=1, and the
// transfer completes on the clock edge where strobe=1 and waitrequest=0 (read
// data is captured on that same edge). All master outputs are decoded from the
// current state, so they cannot change while the state is stalled.
module avalon_fp_mult_master
  import fp_mult_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        avs_s0_address,
  input  logic              avs_s0_read,
  input  logic              avs_s0_write,
  input  logic [31:0]       avs_s0_writedata,
  output logic [31:0]       avs_s0_readdata,
  output logic [ADDR_W-1:0] avm_m0_address,
  output logic              avm_m0_read,
  output logic              avm_m0_write,
  output logic [31:0]       avm_m0_writedata,
  input  logic [31:0]       avm_m0_readdata,
  input  logic              avm_m0_waitrequest,
  output logic [2:0]        avm_m1_address,
  output logic              avm_m1_read,
  output logic              avm_m1_write,
  output logic [31:0]       avm_m1_writedata,
  input  logic [31:0]       avm_m1_readdata,
  input  logic              avm_m1_waitrequest,
  output state_e            dbg_state_o
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  compl_q, compl_d;
  logic              done_q, done_d;
  logic [31:0]       opa_q, opa_d;
  logic [31:0]       opb_q, opb_d;
  logic [31:0]       res_q, res_d;

  logic              busy;
  logic              start;
  logic [ADDR_W-1:0] off8;
  logic [ADDR_W-1:0] off4;
  logic [CNT_W-1:0]  idx_inc;

  // avs_s0_read has no side effects; readdata is a pure address decode.
  logic unused_read;
  assign unused_read = avs_s0_read;

  assign busy        = (state_q != IDLE) && (state_q != DONE);
  assign off8        = ADDR_W'({idx_q, 3'b000});
  assign off4        = ADDR_W'({idx_q, 2'b00});
  assign idx_inc     = idx_q + CNT_W'(1);
  assign dbg_state_o = state_q;

  // CSR read mux; shows register values before any same-cycle write lands.
  always_comb begin
    avs_s0_readdata = '0;
    case (avs_s0_address)
      CSR_SRC: avs_s0_readdata = 32'(src_q);
      CSR_DST: avs_s0_readdata = 32'(dst_q);
      CSR_CNT: avs_s0_readdata = 32'(cnt_q);
      default: begin
        avs_s0_readdata[15:0]          = 16'(compl_q);
        avs_s0_readdata[STAT_BUSY_BIT] = busy;
        avs_s0_readdata[STAT_DONE_BIT] = done_q;
      end
    endcase
  end

  // CSR writes, next-state logic and master-port decode.
  always_comb begin
    state_d          = state_q;
    src_d            = src_q;
    dst_d            = dst_q;
    cnt_d            = cnt_q;
    idx_d            = idx_q;
    compl_d          = compl_q;
    done_d           = done_q;
    opa_d            = opa_q;
    opb_d            = opb_q;
    res_d            = res_q;
    start            = 1'b0;
    avm_m0_address   = '0;
    avm_m0_read      = 1'b0;
    avm_m0_write     = 1'b0;
    avm_m0_writedata = '0;
    avm_m1_address   = '0;
    avm_m1_read      = 1'b0;
    avm_m1_write     = 1'b0;
    avm_m1_writedata = '0;

    // Configuration is frozen while a batch is running.
    if (avs_s0_write && !busy) begin
      case (avs_s0_address)
        CSR_SRC: src_d = ADDR_W'(avs_s0_writedata);
        CSR_DST: dst_d = ADDR_W'(avs_s0_writedata);
        CSR_CNT: cnt_d = avs_s0_writedata[CNT_W-1:0];
        default: start = avs_s0_writedata[CTRL_START_BIT];
      endcase
    end

    case (state_q)
      IDLE: begin
        if (start) state_d = LOAD;
      end
      LOAD: begin
        idx_d = '0;
        if (cnt_q == '0) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          state_d = RD_A;
        end
      end
      RD_A: begin
        avm_m0_read    = 1'b1;
        avm_m0_address = src_q + off8;
        if (!avm_m0_waitrequest) begin
          opa_d   = avm_m0_readdata;
          state_d = RD_B;
        end
      end
      RD_B: begin
        avm_m0_read    = 1'b1;
        avm_m0_address = src_q + off8 + ADDR_W'(4);
        if (!avm_m0_waitrequest) begin
          opb_d   = avm_m0_readdata;
          state_d = WR_OP1;
        end
      end
      WR_OP1: begin
        avm_m1_write     = 1'b1;
        avm_m1_address   = MUL_OP1;
        avm_m1_writedata = opa_q;
        if (!avm_m1_waitrequest) state_d = WR_OP2;
      end
      WR_OP2: begin
        avm_m1_write     = 1'b1;
        avm_m1_address   = MUL_OP2;
        avm_m1_writedata = opb_q;
        if (!avm_m1_waitrequest) state_d = WR_GO;
      end
      WR_GO: begin
        avm_m1_write     = 1'b1;
        avm_m1_address   = MUL_START;
        avm_m1_writedata = 32'd1;
        if (!avm_m1_waitrequest) state_d = RD_RES;
      end
      RD_RES: begin
        // The multiplier stalls this read until its pipeline has finished.
        avm_m1_read    = 1'b1;
        avm_m1_address = MUL_RESULT;
        if (!avm_m1_waitrequest) begin
          res_d   = avm_m1_readdata;
          state_d = WR_MEM;
        end
      end
      WR_MEM: begin
        avm_m0_write     = 1'b1;
        avm_m0_address   = dst_q + off4;
        avm_m0_writedata = res_q;
        if (!avm_m0_waitrequest) state_d = NEXT;
      end
      NEXT: begin
        compl_d = compl_q + CNT_W'(1);
        idx_d   = idx_inc;
        if (idx_inc == cnt_q) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          state_d = RD_A;
        end
      end
      DONE: begin
        state_d = start ? LOAD : IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A new batch clears the previous result status.
    if (start) begin
      done_d  = 1'b0;
      compl_d = '0;
    end
  end

  // State and datapath registers; reset aborts any batch in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      compl_q <= '0;
      done_q  <= 1'b0;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      compl_q <= compl_d;
      done_q  <= done_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
    end
  end

endmodule

// File: tb/tb_avalon_fp_mult_master.sv
// Bench for the batch FP-multiply master: behavioural memory with
// programmable stalls, behavioural multiplier slave, and a scoreboard.
module tb_avalon_fp_mult_master;
  import fp_mult_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [1:0]  s_addr = '0;
  logic        s_rd = 1'b0;
  logic        s_wr = 1'b0;
  logic [31:0] s_wd = '0;
  logic [31:0] s_rdata;
  logic [31:0] m0_addr;
  logic        m0_rd, m0_wr;
  logic [31:0] m0_wd, m0_rdata;
  logic        m0_wait;
  logic [2:0]  m1_addr;
  logic        m1_rd, m1_wr;
  logic [31:0] m1_wd, m1_rdata;
  logic        m1_wait;
  state_e      dbg_state;

  avalon_fp_mult_master #(.ADDR_W(32), .CNT_W(16)) dut (
    .clk                (clk),
    .reset              (rst_n),
    .avs_s0_address     (s_addr),
    .avs_s0_read        (s_rd),
    .avs_s0_write       (s_wr),
    .avs_s0_writedata   (s_wd),
    .avs_s0_readdata    (s_rdata),
    .avm_m0_address     (m0_addr),
    .avm_m0_read        (m0_rd),
    .avm_m0_write       (m0_wr),
    .avm_m0_writedata   (m0_wd),
    .avm_m0_readdata    (m0_rdata),
    .avm_m0_waitrequest (m0_wait),
    .avm_m1_address     (m1_addr),
    .avm_m1_read        (m1_rd),
    .avm_m1_write       (m1_wr),
    .avm_m1_writedata   (m1_wd),
    .avm_m1_readdata    (m1_rdata),
    .avm_m1_waitrequest (m1_wait),
    .dbg_state_o        (dbg_state)
  );

  // ---------------- reference FP multiply (normal operands, RNE) ----------------
  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] p;
    logic [23:0] m;
    logic        g, s;
    int          e;
    p = {1'b1, a[22:0]} * {1'b1, b[22:0]};
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p[47]) begin
      m = {1'b0, p[46:24]}; g = p[23]; s = |p[22:0]; e = e + 1;
    end else begin
      m = {1'b0, p[45:23]}; g = p[22]; s = |p[21:0];
    end
    if (g && (s || m[0])) m = m + 24'd1;
    if (m[23]) begin m = '0; e = e + 1; end
    return {a[31] ^ b[31], 8'(e), m[22:0]};
  endfunction

  // ---------------- memory model ----------------
  logic [31:0] mem [0:1023];
  int          mem_wait_n = 0;
  int          mem_cnt;
  logic        bd_we = 1'b0;
  logic [31:0] bd_addr = '0;
  logic [31:0] bd_data = '0;

  assign m0_wait  = (m0_rd || m0_wr) && (mem_cnt != mem_wait_n);
  assign m0_rdata = mem[m0_addr[11:2]];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_cnt <= 0;
    end else begin
      if (m0_rd || m0_wr) begin
        if (m0_wait) mem_cnt <= mem_cnt + 1;
        else begin
          mem_cnt <= 0;
          if (m0_wr) mem[m0_addr[11:2]] <= m0_wd;
        end
      end
    end
    if (bd_we) mem[bd_addr[11:2]] <= bd_data;
  end

  // ---------------- multiplier slave model ----------------
  logic [31:0] op1_r, op2_r, res_r;
  int          pend;
  logic [2:0]  m1_log [$];

  assign m1_wait  = m1_rd && (pend != 0);
  assign m1_rdata = res_r;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend  <= 0;
      op1_r <= '0;
      op2_r <= '0;
      res_r <= '0;
    end else begin
      if (pend > 0) pend <= pend - 1;
      if (m1_wr) begin
        case (m1_addr)
          3'd0: op1_r <= m1_wd;
          3'd1: op2_r <= m1_wd;
          3'd2: begin res_r <= fp_mul(op1_r, op2_r); pend <= 11; end
          default: ;
        endcase
      end
      if (m1_wr || (m1_rd && !m1_wait)) m1_log.push_back(m1_addr);
    end
  end

  // ---------------- stall-stability monitor and strobe counter ----------------
  logic [67:0] p0_snap, p1_snap;
  logic        p0_stall, p1_stall;
  int          stab_err = 0;
  int          stab_checks = 0;
  int          strobe_cnt = 0;

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p0_stall <= 1'b0;
      p1_stall <= 1'b0;
    end else begin
      if (p0_stall) begin
        stab_checks <= stab_checks + 1;
        assert ({2'b00, m0_addr, m0_rd, m0_wr, m0_wd} === p0_snap) else begin
          stab_err <= stab_err + 1;
          $error("FAIL m0_stall_stable obs=%h exp=%h", {2'b00, m0_addr, m0_rd, m0_wr, m0_wd}, p0_snap);
        end
      end
      if (p1_stall) begin
        stab_checks <= stab_checks + 1;
        assert ({31'd0, m1_addr, m1_rd, m1_wr, m1_wd} === p1_snap) else begin
          stab_err <= stab_err + 1;
          $error("FAIL m1_stall_stable obs=%h exp=%h", {31'd0, m1_addr, m1_rd, m1_wr, m1_wd}, p1_snap);
        end
      end
      p0_stall <= (m0_rd || m0_wr) && m0_wait;
      p1_stall <= (m1_rd || m1_wr) && m1_wait;
      p0_snap  <= {2'b00, m0_addr, m0_rd, m0_wr, m0_wd};
      p1_snap  <= {31'd0, m1_addr, m1_rd, m1_wr, m1_wd};
      if (m0_rd || m0_wr || m1_rd || m1_wr) strobe_cnt <= strobe_cnt + 1;
    end
  end

  // ---------------- scoreboard ----------------
  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic mem_poke(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bd_addr = a; bd_data = d; bd_we = 1'b1;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  task automatic csr_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    s_addr = a; s_wd = d; s_wr = 1'b1;
    @(negedge clk);
    s_wr = 1'b0;
  endtask

  task automatic csr_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    s_addr = a; s_rd = 1'b1;
    #1 d = s_rdata;
    s_rd = 1'b0;
  endtask

  task automatic start_batch(input logic [31:0] src, input logic [31:0] dst, input logic [31:0] cnt);
    csr_write(CSR_SRC, src);
    csr_write(CSR_DST, dst);
    csr_write(CSR_CNT, cnt);
    csr_write(CSR_CTRL, 32'd1);
  endtask

  task automatic wait_done(input string tag);
    logic [31:0] st;
    logic        ok;
    ok = 1'b0;
    for (int c = 0; c < 4000 && !ok; c++) begin
      csr_read(CSR_CTRL, st);
      if (st[STAT_DONE_BIT]) ok = 1'b1;
    end
    check({tag, "_done_seen"}, {31'd0, ok}, 32'd1);
  endtask

  // Fill the scoreboard from the source pairs currently in memory.
  task automatic expect_batch(input logic [31:0] src, input int cnt);
    for (int i = 0; i < cnt; i++)
      exp_q.push_back(fp_mul(mem[(src + 32'(8 * i)) >> 2], mem[(src + 32'(8 * i + 4)) >> 2]));
  endtask

  task automatic check_batch(input string tag, input logic [31:0] dst, input int cnt);
    logic [31:0] st;
    for (int i = 0; i < cnt; i++)
      check($sformatf("%s_item%0d", tag, i), mem[(dst + 32'(4 * i)) >> 2], exp_q.pop_front());
    csr_read(CSR_CTRL, st);
    check({tag, "_status"}, st, 32'h0002_0000 | 32'(cnt));
  endtask

  function automatic logic [31:0] rnd_fp();
    return {1'($urandom_range(0, 1)), 8'($urandom_range(110, 140)), 23'($urandom)};
  endfunction

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [31:0] rd;
    int          base, s0, found;
    logic [31:0] src, dst;
    int          n;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_strobes", {28'd0, m0_rd, m0_wr, m1_rd, m1_wr}, 32'd0);
    check("rst_m0_addr", m0_addr, 32'd0);
    check("rst_m0_wd", m0_wd, 32'd0);
    check("rst_state", {28'd0, dbg_state}, {28'd0, IDLE});
    rst_n = 1'b1;
    for (int a = 0; a < 4; a++) begin
      csr_read(2'(a), rd);
      check($sformatf("rst_csr%0d", a), rd, 32'd0);
    end

    // Single item, known answer
    mem_poke(32'h100, 32'h4059999A);
    mem_poke(32'h104, 32'h4194CCCD);
    mem_poke(32'h108, 32'h41200000);
    mem_poke(32'h10C, 32'h425E0000);
    start_batch(32'h100, 32'h200, 32'd1);
    wait_done("one");
    check("one_prod", mem[32'h200 >> 2], 32'h427CF5C3);
    csr_read(CSR_CTRL, rd);
    check("one_status", rd, 32'h0002_0001);
    csr_read(CSR_CNT, rd);
    check("one_cnt_rb", rd, 32'd1);

    // Two items, multiplier register sequence
    mem_poke(32'h200, 32'd0);
    base = m1_log.size();
    start_batch(32'h100, 32'h200, 32'd2);
    wait_done("two");
    check("two_prod0", mem[32'h200 >> 2], 32'h427CF5C3);
    check("two_prod1", mem[32'h204 >> 2], 32'h440AC000);
    check("two_m1_len", 32'(m1_log.size() - base), 32'd8);
    for (int k = 0; k < 8; k++)
      if (base + k < m1_log.size())
        check($sformatf("two_m1_addr%0d", k), {29'd0, m1_log[base + k]}, 32'(k % 4));

    // Memory stalls three cycles on every access
    mem_poke(32'h200, 32'd0);
    mem_poke(32'h204, 32'd0);
    mem_wait_n = 3;
    s0 = stab_checks;
    start_batch(32'h100, 32'h200, 32'd2);
    wait_done("stall");
    check("stall_prod0", mem[32'h200 >> 2], 32'h427CF5C3);
    check("stall_prod1", mem[32'h204 >> 2], 32'h440AC000);
    check("stall_monitored", {31'd0, (stab_checks - s0) >= 24}, 32'd1);
    check("stall_stable_errs", 32'(stab_err), 32'd0);
    mem_wait_n = 0;

    // Zero count: done quickly, no bus traffic
    s0 = strobe_cnt;
    csr_write(CSR_CNT, 32'd0);
    csr_write(CSR_CTRL, 32'd1);
    found = 0;
    for (int c = 1; c <= 3 && found == 0; c++) begin
      csr_read(CSR_CTRL, rd);
      if (rd[STAT_DONE_BIT]) found = c;
    end
    check("zero_done_in3", {31'd0, found != 0}, 32'd1);
    check("zero_status", rd, 32'h0002_0000);
    check("zero_no_strobe", 32'(strobe_cnt - s0), 32'd0);

    // Writes while busy are ignored
    mem_poke(32'h200, 32'd0);
    mem_poke(32'h204, 32'd0);
    expect_batch(32'h100, 2);
    start_batch(32'h100, 32'h200, 32'd2);
    repeat (5) @(negedge clk);
    csr_write(CSR_CNT, 32'd5);
    csr_write(CSR_CTRL, 32'd1);
    csr_write(CSR_SRC, 32'h300);
    wait_done("busywr");
    check_batch("busywr", 32'h200, 2);
    csr_read(CSR_CNT, rd);
    check("busywr_cnt_rb", rd, 32'd2);
    csr_read(CSR_SRC, rd);
    check("busywr_src_rb", rd, 32'h100);
    repeat (20) @(negedge clk);
    csr_read(CSR_CTRL, rd);
    check("busywr_no_restart", rd, 32'h0002_0002);

    // Randomized batches against the scoreboard
    for (int t = 0; t < 6; t++) begin
      n   = $urandom_range(1, 6);
      src = 32'h400 + 32'(64 * $urandom_range(0, 3));
      dst = 32'h800 + 32'(32 * $urandom_range(0, 3));
      mem_wait_n = $urandom_range(0, 2);
      for (int i = 0; i < 2 * n; i++) mem_poke(src + 32'(4 * i), rnd_fp());
      for (int i = 0; i < n; i++) mem_poke(dst + 32'(4 * i), 32'hDEAD_BEEF);
      expect_batch(src, n);
      start_batch(src, dst, 32'(n));
      wait_done($sformatf("rnd%0d", t));
      check_batch($sformatf("rnd%0d", t), dst, n);
    end
    mem_wait_n = 0;
    check("rnd_stable_errs", 32'(stab_err), 32'd0);

    // Reset during the result read of item 1
    mem_poke(32'h110, 32'h3FC00000);
    mem_poke(32'h114, 32'h40000000);
    start_batch(32'h100, 32'h300, 32'd3);
    s_addr = CSR_CTRL;
    found = 0;
    for (int c = 0; c < 2000 && found == 0; c++) begin
      @(negedge clk);
      if (dbg_state == RD_RES && s_rdata[15:0] == 16'd1) found = 1;
    end
    check("rst_mid_reached", 32'(found), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_strobes", {28'd0, m0_rd, m0_wr, m1_rd, m1_wr}, 32'd0);
    check("rst_mid_m1_addr", {29'd0, m1_addr}, 32'd0);
    check("rst_mid_status", s_rdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    csr_read(CSR_CTRL, rd);
    check("rst_mid_done_low", rd, 32'd0);
    check("rst_mid_state", {28'd0, dbg_state}, {28'd0, IDLE});

    // Fresh batch after the abort
    for (int i = 0; i < 3; i++) mem_poke(32'h300 + 32'(4 * i), 32'd0);
    expect_batch(32'h100, 3);
    start_batch(32'h100, 32'h300, 32'd3);
    wait_done("after_rst");
    check_batch("after_rst", 32'h300, 3);
    check("after_rst_item2", mem[32'h308 >> 2], 32'h40400000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL global_timeout obs=running exp=finished");
    $fatal(1, "time limit");
  end

endmodule
